// File: rtl/sent_pkg.sv
// Shared SENT constants and the CRC-arbiter FSM state type.
package sent_pkg;

   localparam int NIB_W           = 4;
   localparam int DATA_W          = 24;
   localparam int LEN_W           = 3;
   localparam int TIMEOUT_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sent_rr_arbiter.sv
// Combinational round-robin picker: first requester scanning upward from ptr+1, wrapping.
module sent_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   // Scan from the farthest candidate down so the nearest one after ptr wins.
   always_comb begin
      int cand;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = 0;
      for (int i = N; i >= 1; i--) begin
         cand = (int'(ptr) + i) % N;
         if (req[IDX_W'(cand)]) begin
            gnt_idx   = IDX_W'(cand);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sent_crc_arbiter.sv
// Shares one SENT CRC engine among NUM_CH channels with round-robin grants.
// Optional WAIT watchdog enabled by defining SENT_CRC_ARB_TIMEOUT_EN.
module sent_crc_arbiter
   import sent_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CH_W           = $clog2(NUM_CH),
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_mode,
   input  logic [LEN_W*NUM_CH-1:0]    ch_len,
   input  logic [DATA_W*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]          ch_ack,
   output logic [NIB_W-1:0]           ch_crc,
   output logic                       ch_err,
   output logic                       eng_req,
   output logic                       eng_mode,
   output logic [LEN_W-1:0]           eng_len,
   output logic [DATA_W-1:0]          eng_data,
   input  logic                       eng_ack,
   input  logic [NIB_W-1:0]           eng_crc,
   output logic                       busy,
   output logic [CH_W-1:0]            grant_id
);

   if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("sent_crc_arbiter: illegal parameter value");
   end

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [CH_W-1:0]   grant_id_q, grant_id_d;
   logic              eng_mode_q, eng_mode_d;
   logic [LEN_W-1:0]  eng_len_q, eng_len_d;
   logic [DATA_W-1:0] eng_data_q, eng_data_d;
   logic [NIB_W-1:0]  ch_crc_q, ch_crc_d;
   logic [CH_W-1:0]   arb_idx;
   logic              arb_valid;
   logic [LEN_W-1:0]  sel_len;
   logic [DATA_W-1:0] sel_data;

`ifdef SENT_CRC_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   sent_rr_arbiter #(.N(NUM_CH), .IDX_W(CH_W)) u_rr (
      .req       (ch_req),
      .ptr       (ptr_q),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      sel_len  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (arb_idx == CH_W'(i)) begin
            sel_len  = ch_len[i*LEN_W +: LEN_W];
            sel_data = ch_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      eng_mode_d = eng_mode_q;
      eng_len_d  = eng_len_q;
      eng_data_d = eng_data_q;
      ch_crc_d   = ch_crc_q;
`ifdef SENT_CRC_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_id_d = arb_idx;
               ptr_d      = arb_idx;
               eng_mode_d = ch_mode[arb_idx];
               eng_len_d  = sel_len;
               eng_data_d = sel_data;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef SENT_CRC_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (eng_ack) begin
               ch_crc_d = eng_crc;
               state_d  = ST_DONE;
`ifdef SENT_CRC_ARB_TIMEOUT_EN
               err_d    = 1'b0;
`endif
            end
`ifdef SENT_CRC_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + TO_W'(1);
               // Last silent WAIT cycle: the counter reaches the limit here.
               if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  ch_crc_d = '0;
                  err_d    = 1'b1;
                  state_d  = ST_DONE;
               end
            end
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= CH_W'(NUM_CH - 1);
         grant_id_q <= '0;
         eng_mode_q <= 1'b0;
         eng_len_q  <= '0;
         eng_data_q <= '0;
         ch_crc_q   <= '0;
`ifdef SENT_CRC_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         eng_mode_q <= eng_mode_d;
         eng_len_q  <= eng_len_d;
         eng_data_q <= eng_data_d;
         ch_crc_q   <= ch_crc_d;
`ifdef SENT_CRC_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   always_comb begin
      ch_ack = '0;
      if (state_q == ST_DONE) ch_ack[grant_id_q] = 1'b1;
   end

`ifdef SENT_CRC_ARB_TIMEOUT_EN
   assign ch_err = err_q && (state_q == ST_DONE);
`else
   assign ch_err = 1'b0;
`endif

   assign ch_crc   = ch_crc_q;
   assign eng_req  = (state_q == ST_ISSUE);
   assign eng_mode = eng_mode_q;
   assign eng_len  = eng_len_q;
   assign eng_data = eng_data_q;
   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_sent_crc_arbiter.sv
// Directed bench for sent_crc_arbiter; engine responses are driven inline.
module tb_sent_crc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_req, ch_mode, ch_ack;
   logic [11:0] ch_len;
   logic [95:0] ch_data;
   logic [3:0]  ch_crc, eng_crc;
   logic        ch_err, eng_req, eng_mode, eng_ack, busy;
   logic [2:0]  eng_len;
   logic [23:0] eng_data;
   logic [1:0]  grant_id;

   int checks = 0;
   int errors = 0;

   logic [2:0]  len_t  [4] = '{3'd3, 3'd6, 3'd0, 3'd7};
   logic [23:0] data_t [4] = '{24'h00ABC0, 24'h123456, 24'hFEDCBA, 24'h5A5A5A};
   logic        mode_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [3:0]  crc_t  [4] = '{4'h1, 4'hA, 4'h7, 4'h3};

   sent_crc_arbiter #(.NUM_CH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_req   (ch_req),
      .ch_mode  (ch_mode),
      .ch_len   (ch_len),
      .ch_data  (ch_data),
      .ch_ack   (ch_ack),
      .ch_crc   (ch_crc),
      .ch_err   (ch_err),
      .eng_req  (eng_req),
      .eng_mode (eng_mode),
      .eng_len  (eng_len),
      .eng_data (eng_data),
      .eng_ack  (eng_ack),
      .eng_crc  (eng_crc),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_cfg();
      for (int i = 0; i < 4; i++) begin
         ch_len[3*i +: 3]   = len_t[i];
         ch_data[24*i +: 24] = data_t[i];
         ch_mode[i]          = mode_t[i];
      end
   endtask

   // Called on a falling edge; returns on the falling edge where eng_req is seen.
   task automatic wait_eng_req(input int max_cyc, output int cyc);
      cyc = 0;
      while (eng_req !== 1'b1 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      chk("eng_req_seen", {31'd0, eng_req}, 32'd1);
   endtask

   task automatic serve(input int ch, input int delay, input bit drop, output int lat);
      wait_eng_req(8, lat);
      chk("grant_id", grant_id, ch);
      chk("eng_len", eng_len, len_t[ch]);
      chk("eng_data", eng_data, data_t[ch]);
      chk("eng_mode", eng_mode, mode_t[ch]);
      repeat (delay) begin
         @(negedge clk);
         chk("eng_req_pulse", eng_req, 0);
      end
      eng_ack = 1'b1;
      eng_crc = crc_t[ch];
      @(negedge clk);
      eng_ack = 1'b0;
      eng_crc = 4'h0;
      chk("ch_ack", ch_ack, 32'd1 << ch);
      chk("ch_crc", ch_crc, crc_t[ch]);
      chk("ch_err", ch_err, 0);
      if (drop) ch_req[ch] = 1'b0;
   endtask

   initial begin
      int lat;
      int cyc;
      int bad;
      rst     = 1'b1;
      ch_req  = '0;
      ch_mode = '0;
      ch_len  = '0;
      ch_data = '0;
      eng_ack = 1'b0;
      eng_crc = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ch_ack", ch_ack, 0);
      chk("rst_eng_req", eng_req, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_eng_data", eng_data, 0);
      chk("rst_ch_crc", ch_crc, 0);
      rst = 1'b0;
      load_cfg();
      @(negedge clk);

      // 1: single request on ch1, engine answers 9 cycles after eng_req
      ch_req[1] = 1'b1;
      serve(1, 9, 1'b1, lat);
      chk("t1_latency", lat, 1);
      @(negedge clk);
      chk("t1_ack_gone", ch_ack, 0);
      chk("t1_idle", busy, 0);

      // 2: all four at once after reset -> 0,1,2,3
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ch_req = 4'b1111;
      serve(0, 2, 1'b1, lat);
      chk("t2_first_latency", lat, 1);
      serve(1, 2, 1'b1, lat);
      chk("t2_gap", lat, 2);
      serve(2, 2, 1'b1, lat);
      serve(3, 2, 1'b1, lat);
      @(negedge clk);

      // 3: ch0 and ch2 held continuously -> alternate, one idle cycle between grants
      ch_req = 4'b0101;
      for (int k = 0; k < 6; k++) begin
         serve((k % 2 == 0) ? 0 : 2, 1, 1'b0, lat);
         chk("t3_latency", lat, 1);
         if (k == 5) begin
            ch_req = '0;
         end
         @(negedge clk);
         chk("t3_busy_gap", busy, 0);
      end

      // 4: spurious eng_ack in IDLE and in ISSUE
      eng_ack = 1'b1;
      eng_crc = 4'h5;
      @(negedge clk);
      eng_ack = 1'b0;
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_ack", ch_ack, 0);
      chk("t4_idle_crc", ch_crc, 4'h7);
      chk("t4_idle_eng_req", eng_req, 0);
      ch_req[3] = 1'b1;
      wait_eng_req(4, lat);
      chk("t4_grant", grant_id, 3);
      eng_ack = 1'b1;
      eng_crc = 4'hF;
      @(negedge clk);
      eng_ack = 1'b0;
      chk("t4_issue_ack", ch_ack, 0);
      chk("t4_issue_busy", busy, 1);
      chk("t4_issue_crc", ch_crc, 4'h7);
      chk("t4_issue_eng_req", eng_req, 0);
      @(negedge clk);
      chk("t4_still_wait", ch_ack, 0);
      eng_ack = 1'b1;
      eng_crc = crc_t[3];
      @(negedge clk);
      eng_ack = 1'b0;
      chk("t4_ch_ack", ch_ack, 4'b1000);
      chk("t4_ch_crc", ch_crc, crc_t[3]);
      ch_req = '0;
      @(negedge clk);

      // 5: asynchronous reset during WAIT
      ch_req[2] = 1'b1;
      wait_eng_req(4, lat);
      chk("t5_grant", grant_id, 2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_grant_id", grant_id, 0);
      chk("t5_eng_len", eng_len, 0);
      chk("t5_eng_data", eng_data, 0);
      chk("t5_eng_mode", eng_mode, 0);
      chk("t5_ch_crc", ch_crc, 0);
      chk("t5_ch_ack", ch_ack, 0);
      chk("t5_eng_req", eng_req, 0);
      ch_req = '0;
      @(negedge clk);
      rst = 1'b0;
      eng_ack = 1'b1;
      eng_crc = 4'hC;
      @(negedge clk);
      eng_ack = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (ch_ack !== 4'b0 || busy !== 1'b0) bad++;
      end
      chk("t5_late_ack_ignored", bad, 0);
      ch_req = 4'b1001;
      serve(0, 2, 1'b1, lat);
      serve(3, 2, 1'b1, lat);
      @(negedge clk);

      // 6: engine never answers
      ch_req[1] = 1'b1;
      wait_eng_req(4, lat);
`ifdef SENT_CRC_ARB_TIMEOUT_EN
      cyc = 0;
      while (ch_ack === 4'b0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("t6_timeout_cycles", cyc, 17);
      chk("t6_ch_ack", ch_ack, 4'b0010);
      chk("t6_ch_err", ch_err, 1);
      chk("t6_ch_crc", ch_crc, 0);
      ch_req = '0;
      @(negedge clk);
      chk("t6_err_cleared", ch_err, 0);
`else
      cyc = 0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         cyc++;
         if (ch_ack !== 4'b0 || busy !== 1'b1 || ch_err !== 1'b0) bad++;
      end
      chk("t6_wait_hold", bad, 0);
      ch_req = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_reset_idle", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sent_crc_arbiter.md
Name: sent_crc_arbiter

Overview:
Shares one SENT CRC engine between NUM_CH SENT transmit channels. Arbitrates among pending CRC requests round-robin and latches the winner's frame length, data and CRC mode. Issues a single-cycle request to the engine, waits for its completion pulse, then returns the 4-bit CRC to the granted channel with a one-cycle ack. Sits between the per-channel SENT frame builders and the single CRC engine instance.

Parameters:
NUM_CH, 4, number of requesting channels; legal range 2..8.
CH_W, $clog2(NUM_CH), channel index width; derived, do not override.
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ch_req  in  NUM_CH  per-channel CRC request level; held until that channel's ch_ack
ch_mode  in  NUM_CH  per-channel CRC mode (1 = recommended mode with extra zero nibble)
ch_len  in  3*NUM_CH  per-channel nibble count, channel i at [3i+2:3i]
ch_data  in  24*NUM_CH  per-channel frame data, MSB nibble first, channel i at [24i+23:24i]
ch_ack  out  NUM_CH  one-hot, one-cycle completion pulse to the granted channel
ch_crc  out  4  CRC result; valid only while any ch_ack bit is high
ch_err  out  1  timeout flag; valid with ch_ack
eng_req  out  1  one-cycle request pulse to the CRC engine
eng_mode  out  1  mode to the engine; stable from ISSUE through engine ack
eng_len  out  3  latched length to the engine
eng_data  out  24  latched data to the engine
eng_ack  in  1  engine completion pulse
eng_crc  in  4  engine result; valid with eng_ack
busy  out  1  high in every state except IDLE
grant_id  out  CH_W  index of the current or last granted channel

Behaviour:
- Reset: state IDLE. ch_ack=0, ch_crc=0, ch_err=0, eng_req=0, eng_mode/eng_len/eng_data=0, busy=0, grant_id=0. RR pointer = NUM_CH-1, so channel 0 has first priority.
- Reset mid-operation: abort immediately. Any engine result arriving after reset is ignored. Requesters must re-request.
- FSM (registered, one-hot or binary encoding from the package):
  - IDLE: if |ch_req, pick the first requesting channel scanning upward from pointer+1, wrapping modulo NUM_CH. Latch that channel's index, mode, len and data into the eng_* registers, update the pointer to the winner, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: eng_req=1 for exactly one cycle, then go to WAIT.
  - WAIT: on eng_ack, capture eng_crc into ch_crc, go to DONE. An eng_ack seen in any other state is ignored.
  - DONE: ch_ack[grant_id]=1 and ch_err=0 for one cycle, then go to IDLE. In all other states ch_crc keeps its last value.
- Latency: request seen in IDLE at cycle T gives eng_req at T+1. An eng_ack at cycle K gives ch_ack at K+1. Minimum gap between back-to-back grants: DONE to IDLE to ISSUE, i.e. 2 cycles.
- Requester rule: deassert ch_req the cycle after ch_ack. The IDLE cycle following DONE therefore never re-grants the same transaction.
- ch_req changes from non-granted channels have no effect on an active transaction. ch_len/ch_data/ch_mode are sampled only at grant.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness: each continuously requesting channel is served within NUM_CH grants.
- ch_len=0 is passed through unchanged; the engine defines the result.

Optional Feature:
Macro SENT_CRC_ARB_TIMEOUT_EN.
- Defined: a WAIT counter, cleared in ISSUE, increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no eng_ack, go to DONE with ch_err=1 and ch_crc=0. The counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter. WAIT waits indefinitely. ch_err is tied to 0.

Decomposition:
- Package sent_pkg:
  - nibble width 4, data width 24, length width 3
  - FSM state enum IDLE/ISSUE/WAIT/DONE
  - default TIMEOUT_CYCLES
- Sub-module sent_rr_arbiter: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are grant index and grant-valid. It is instantiated once and is reusable by other shared SENT resources.

Test Plan:
1. Single request: ch1 with len=6, data=24'h123456, mode=1. Engine model acks 9 cycles after eng_req with crc=4'hA. Expect eng_len=6, eng_data=24'h123456, eng_mode=1, one eng_req pulse, ch_ack=4'b0010 one cycle after eng_ack, ch_crc=4'hA, ch_err=0.
2. All four channels request together from reset: grant order 0,1,2,3. Each ch_ack is one-hot, and each ch_crc matches that channel's model result.
3. Fairness: ch0 and ch2 request continuously for 6 transactions. Grants alternate 0,2,0,2,0,2 and busy never drops for more than 1 cycle.
4. Spurious eng_ack asserted in IDLE and in ISSUE: state and outputs unchanged, no ch_ack.
5. Reset asserted during WAIT: all outputs return to reset values asynchronously. A later eng_ack produces no ch_ack. The next grant goes to channel 0.
6. With SENT_CRC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the engine never acks: ch_ack at eng_req+17 cycles with ch_err=1, ch_crc=0. Without the macro the FSM stays in WAIT for 100 cycles.
